wgt_rf_loader: RTL and testbench

WGT_RF_LOADER -- requirements
Module: wgt_rf_loader

---
 rtl/wgt_loader_pkg.sv | 24 ++
 rtl/wgt_lane_mask.sv | 17 +
 rtl/wgt_rf_loader.sv | 100 ++++++++++
 tb/tb_wgt_rf_loader.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/wgt_loader_pkg.sv
// Shared types and defaults for the weight register-file loader.
package wgt_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int unsigned DEF_DATA_WIDTH   = 8;
  localparam int unsigned DEF_BUFFER_SIZE  = 27;
  localparam int unsigned DEF_BUFFER_COUNT = 16;
  localparam int unsigned DEF_ADDR_WIDTH   = 16;

  // A requested lane count of 0 or above the lane total means "all lanes".
  function automatic int unsigned clamp_lanes(input logic [4:0] n, input int unsigned count);
    int unsigned nv;
    nv = 32'(n);
    if (nv == 0 || nv > count) return count;
    return nv;
  endfunction

endpackage

// File: rtl/wgt_lane_mask.sv
// Converts an active-lane count into a thermometer mask (lane i active when i < n).
module wgt_lane_mask #(
  parameter int unsigned LANES = 16,
  parameter int unsigned NW    = 5
) (
  input  logic [NW-1:0]    i_n,
  output logic [LANES-1:0] o_mask
);

  always_comb begin
    o_mask = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      o_mask[i] = (i < 32'(i_n));
    end
  end

endmodule

// File: rtl/wgt_rf_loader.sv
// Streams BUFFER_SIZE weight words from memory into per-lane RF shift registers.
// Optional WGT_LOADER_ZERO_PAD_EN: inactive lanes shift in lockstep carrying zeros.
module wgt_rf_loader
  import wgt_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned BUFFER_SIZE  = DEF_BUFFER_SIZE,
  parameter int unsigned BUFFER_COUNT = DEF_BUFFER_COUNT,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  input  logic [4:0]                         num_filters,
  input  logic                               hold,
  output logic                               wgt_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]              wgt_mem_addr,
  input  logic [BUFFER_COUNT*DATA_WIDTH-1:0] wgt_mem_data,
  output logic                               select_wgt,
  output logic [BUFFER_COUNT-1:0]            wgt_RF_shift_en,
  output logic [BUFFER_COUNT*DATA_WIDTH-1:0] data_out,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned CW = $clog2(BUFFER_SIZE + 1);
  localparam int unsigned NW = $clog2(BUFFER_COUNT + 1);

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [NW-1:0]           r_n;
  logic                    r_pend;
  logic                    w_rd;
  logic [BUFFER_COUNT-1:0] w_mask;

  wgt_lane_mask #(
    .LANES (BUFFER_COUNT),
    .NW    (NW)
  ) u_mask (
    .i_n    (r_n),
    .o_mask (w_mask)
  );

  assign w_rd = (r_state == S_LOAD) && !hold;

  // r_pend marks a read whose data arrives next cycle; reset drops it so an
  // in-flight read of an aborted load never shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_base  <= '0;
      r_n     <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_pend <= w_rd;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base  <= base_addr;
            r_n     <= NW'(clamp_lanes(num_filters, BUFFER_COUNT));
            r_cnt   <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_rd) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(BUFFER_SIZE - 1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wgt_mem_rd_en = w_rd;
  assign wgt_mem_addr  = (r_state == S_LOAD) ? r_base + ADDR_WIDTH'(r_cnt) : '0;
  assign busy          = (r_state != S_IDLE);
  assign select_wgt    = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);

  always_comb begin
    data_out = '0;
`ifdef WGT_LOADER_ZERO_PAD_EN
    wgt_RF_shift_en = r_pend ? '1 : '0;
    for (int unsigned i = 0; i < BUFFER_COUNT; i++) begin
      if (r_pend && w_mask[i]) data_out[i*DATA_WIDTH +: DATA_WIDTH] = wgt_mem_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
`else
    wgt_RF_shift_en = r_pend ? w_mask : '0;
    if (r_pend) data_out = wgt_mem_data;
`endif
  end

endmodule

// File: tb/tb_wgt_rf_loader.sv
// Scoreboard bench for wgt_rf_loader: memory model, per-cycle output checks, queued shift expectations.
module tb_wgt_rf_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [15:0]  base_addr;
  logic [4:0]   num_filters;
  logic         hold;
  logic         wgt_mem_rd_en;
  logic [15:0]  wgt_mem_addr;
  logic [127:0] wgt_mem_data;
  logic         select_wgt;
  logic [15:0]  wgt_RF_shift_en;
  logic [127:0] data_out;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  wgt_rf_loader #(
    .DATA_WIDTH   (8),
    .BUFFER_SIZE  (27),
    .BUFFER_COUNT (16),
    .ADDR_WIDTH   (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .base_addr       (base_addr),
    .num_filters     (num_filters),
    .hold            (hold),
    .wgt_mem_rd_en   (wgt_mem_rd_en),
    .wgt_mem_addr    (wgt_mem_addr),
    .wgt_mem_data    (wgt_mem_data),
    .select_wgt      (select_wgt),
    .wgt_RF_shift_en (wgt_RF_shift_en),
    .data_out        (data_out),
    .busy            (busy),
    .done            (done)
  );

  function automatic logic [127:0] mem_word(input logic [15:0] a);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w[i*8 +: 8] = (a[7:0] ^ a[15:8]) + 8'(i * 29 + 1);
    return w;
  endfunction

  // One-cycle-latency weight memory; non-read cycles return a junk pattern.
  always @(posedge clk) begin
    if (wgt_mem_rd_en) wgt_mem_data <= mem_word(wgt_mem_addr);
    else               wgt_mem_data <= {8{16'hDEAD}};
  end

  typedef struct packed {
    logic [15:0]  sh;
    logic [127:0] dm;
    logic [127:0] d;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_load(input logic [15:0] base, input logic [4:0] nf,
                          input int hold_lo, input int hold_hi, input int rst_at,
                          input int exp_done, input int exp_shifts);
    int           m_st;
    int           issued;
    int           done_cyc;
    int           n_sh;
    int           nn;
    logic         exp_rd;
    logic [15:0]  lmask;
    logic [127:0] bmask;
    logic [15:0]  ea;
    exp_t         e;

    nn = (nf == 0 || nf > 16) ? 16 : int'(nf);
    lmask = '0;
    bmask = '0;
    for (int i = 0; i < nn; i++) begin
      lmask[i] = 1'b1;
      bmask[i*8 +: 8] = 8'hFF;
    end
    m_st = 0; issued = 0; done_cyc = 999; n_sh = 0;
    sbq.delete();

    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_filters = nf; hold = 1'b0; rst = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start = (c == 3 || c == 6);
        hold  = (c >= hold_lo && c <= hold_hi);
        rst   = (c == rst_at);
        base_addr = 16'h5A5A;
        num_filters = 5'd3;
      end
      @(negedge clk);
      exp_rd = (m_st == 1) && !hold;
      ea = base + 16'(issued);
      check("rd_en",  128'(wgt_mem_rd_en), 128'(exp_rd));
      check("addr",   128'(wgt_mem_addr),  (m_st == 1) ? 128'(ea) : 128'd0);
      check("busy",   128'(busy),          128'(m_st != 0));
      check("select", 128'(select_wgt),    128'(m_st != 0));
      check("done",   128'(done),          128'(m_st == 3));
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("shift_en", 128'(wgt_RF_shift_en), 128'(e.sh));
        check("data_out", data_out & e.dm, e.d);
      end else begin
        check("shift_idle", 128'(wgt_RF_shift_en), 128'd0);
        check("data_idle",  data_out, 128'd0);
      end
      if (wgt_RF_shift_en != 0) n_sh++;
      if (done && done_cyc == 999) done_cyc = c;
      if (exp_rd) begin
`ifdef WGT_LOADER_ZERO_PAD_EN
        e.sh = 16'hFFFF;
        e.dm = '1;
`else
        e.sh = lmask;
        e.dm = bmask;
`endif
        e.d = mem_word(ea) & bmask;
        sbq.push_back(e);
        issued++;
      end
      if (rst) begin
        m_st = 0;
        sbq.delete();
      end else begin
        case (m_st)
          0: if (start) begin m_st = 1; issued = 0; end
          1: if (exp_rd && issued == 27) m_st = 2;
          2: m_st = 3;
          default: m_st = 0;
        endcase
      end
    end
    start = 1'b0; hold = 1'b0; rst = 1'b0;
    check("done_cycle", 128'(done_cyc), 128'(exp_done));
    check("shift_count", 128'(n_sh), 128'(exp_shifts));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_filters = '0; hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", 128'(wgt_mem_rd_en), 128'd0);
    check("rst_addr",  128'(wgt_mem_addr),  128'd0);
    check("rst_busy",  128'(busy),          128'd0);
    check("rst_sel",   128'(select_wgt),    128'd0);
    check("rst_done",  128'(done),          128'd0);
    check("rst_shift", 128'(wgt_RF_shift_en), 128'd0);
    check("rst_data",  data_out,            128'd0);
    rst = 1'b0;

    // Start sampled at end of cycle 0; done at cycle 29 = BUFFER_SIZE+3 cycles inclusive.
    run_load(16'h0100, 5'd16, -1, -1, -1, 29, 27);
    run_load(16'h0040, 5'd5,  -1, -1, -1, 29, 27);
    run_load(16'h0200, 5'd16,  5,  9, -1, 34, 27);
    run_load(16'hFFF0, 5'd7,  -1, -1, -1, 29, 27);
    run_load(16'h0300, 5'd16, -1, -1, 10, 999, 9);
    run_load(16'h0400, 5'd0,  -1, -1, -1, 29, 27);
    run_load(16'h0500, 5'd20, -1, -1, -1, 29, 27);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
